// File: rtl/background_model_ctrl.sv
// background_model_ctrl
// Sequencing and configuration controller for one background-model channel.
// It supplies the external datapath with the blend weights. It forces an
// initialisation frame (weight 128) after reset or on request. Alpha updates
// are applied only at frame starts. The valid/sof/eol sideband is delayed so
// that it lines up with the datapath result.
// Optional build macro: BG_MODEL_CTRL_STATS_EN adds frame_cnt / init_active.
module background_model_ctrl #(
    parameter int         DP_LATENCY  = 4,     // must be >= 2
    parameter logic [7:0] ALPHA_RESET = 8'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eol,
    input  logic [7:0]  in_frame,
    input  logic [7:0]  in_background,
    input  logic        cfg_valid,
    input  logic [7:0]  cfg_alpha,
    output logic        cfg_ready,
    input  logic        init_req,
    output logic [7:0]  dp_frame,
    output logic [7:0]  dp_background,
    output logic [7:0]  dp_alpha,
    output logic [7:0]  dp_one_minus_alpha,
    input  logic [7:0]  dp_obackground,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eol,
    output logic [7:0]  out_background,
    output logic        busy
`ifdef BG_MODEL_CTRL_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic        init_active
`endif
);

    localparam logic [7:0] ALPHA_ONE = 8'd128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] active_alpha;
    logic [7:0] pending_alpha;
    logic       pending;
    logic       pending_nxt;
    logic       init_pending;

    logic       sof_acc;
    logic       cfg_hs;
    logic       clr_init;
    logic       apply_pending;
    logic [7:0] eff_alpha;

    // Sideband delay line, one bit per stage; the stage 0 entry is the newest.
    logic [DP_LATENCY-1:0] vld_p;
    logic [DP_LATENCY-1:0] sof_p;
    logic [DP_LATENCY-1:0] eol_p;

    // Requests above unity weight are limited to 1.0 (128 in Q1.7).
    function automatic logic [7:0] clamp_alpha(input logic [7:0] a);
        return (a > ALPHA_ONE) ? ALPHA_ONE : a;
    endfunction

    assign sof_acc = in_valid & in_sof;
    assign cfg_hs  = cfg_valid & cfg_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame-start decision: choose INIT or RUN and decide whether the pending alpha is consumed
    always_comb begin
        state_nxt     = state;
        clr_init      = 1'b0;
        apply_pending = 1'b0;
        if (sof_acc) begin
            if (init_pending) begin
                state_nxt = ST_INIT;
                clr_init  = 1'b1;
            end else begin
                state_nxt     = ST_RUN;
                apply_pending = pending;
            end
        end
    end

    // Effective weight; on a sof pixel the selection already reflects the new frame
    always_comb begin
        eff_alpha = active_alpha;
        if (sof_acc) begin
            if (init_pending) begin
                eff_alpha = ALPHA_ONE;
            end else if (pending) begin
                eff_alpha = pending_alpha;
            end
        end else if (state == ST_INIT) begin
            eff_alpha = ALPHA_ONE;
        end
    end

    // Pending flag next value; a handshake needs pending=0 and a consume needs pending=1
    always_comb begin
        pending_nxt = pending;
        if (cfg_hs) begin
            pending_nxt = 1'b1;
        end else if (apply_pending) begin
            pending_nxt = 1'b0;
        end
    end

    // Alpha control registers, init request flag and registered cfg_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_alpha <= ALPHA_RESET;
            pending      <= 1'b0;
            init_pending <= 1'b1;
            cfg_ready    <= 1'b0;
        end else begin
            pending   <= pending_nxt;
            cfg_ready <= ~pending_nxt;
            if (apply_pending) begin
                active_alpha <= pending_alpha;
            end
            // A new request outranks the clear, so init_req on a sof cycle targets the next frame
            if (init_req) begin
                init_pending <= 1'b1;
            end else if (clr_init) begin
                init_pending <= 1'b0;
            end
        end
    end

    // Requested alpha capture; only meaningful while pending is set, so it has no reset
    always_ff @(posedge clk) begin
        if (cfg_hs) begin
            pending_alpha <= clamp_alpha(cfg_alpha);
        end
    end

    // Sideband delay line matching the datapath latency; reset drops in-flight pixels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
            sof_p <= '0;
            eol_p <= '0;
        end else begin
            vld_p <= {vld_p[DP_LATENCY-2:0], in_valid};
            sof_p <= {sof_p[DP_LATENCY-2:0], sof_acc};
            eol_p <= {eol_p[DP_LATENCY-2:0], in_valid & in_eol};
        end
    end

    assign dp_frame           = in_frame;
    assign dp_background      = in_background;
    assign dp_alpha           = eff_alpha;
    assign dp_one_minus_alpha = ALPHA_ONE - eff_alpha;

    assign out_valid      = vld_p[DP_LATENCY-1];
    assign out_sof        = sof_p[DP_LATENCY-1];
    assign out_eol        = eol_p[DP_LATENCY-1];
    assign out_background = out_valid ? dp_obackground : 8'd0;

    assign busy = (state != ST_IDLE) | (|vld_p);

`ifdef BG_MODEL_CTRL_STATS_EN
    // Accepted frame starts, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (sof_acc) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign init_active = (state == ST_INIT);
`endif

endmodule

// File: tb/tb_background_model_ctrl.sv
// tb_background_model_ctrl
// Directed bench. Each issued pixel pushes its hand-computed result into a
// queue. A monitor on the falling edge pops from the queue and checks every
// out_valid beat against it. The external 4-cycle datapath is modelled here.
module tb_background_model_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sof, in_eol;
    logic [7:0]  in_frame, in_background;
    logic        cfg_valid;
    logic [7:0]  cfg_alpha;
    logic        cfg_ready;
    logic        init_req;
    logic [7:0]  dp_frame, dp_background, dp_alpha, dp_one_minus_alpha;
    logic [7:0]  dp_obackground;
    logic        out_valid, out_sof, out_eol;
    logic [7:0]  out_background;
    logic        busy;
`ifdef BG_MODEL_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic        init_active;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    typedef struct {
        int         cyc;
        bit         sof;
        bit         eol;
        logic [7:0] bg;
    } exp_t;

    exp_t exp_q[$];

    background_model_ctrl #(.DP_LATENCY(4), .ALPHA_RESET(8'd8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_sof             (in_sof),
        .in_eol             (in_eol),
        .in_frame           (in_frame),
        .in_background      (in_background),
        .cfg_valid          (cfg_valid),
        .cfg_alpha          (cfg_alpha),
        .cfg_ready          (cfg_ready),
        .init_req           (init_req),
        .dp_frame           (dp_frame),
        .dp_background      (dp_background),
        .dp_alpha           (dp_alpha),
        .dp_one_minus_alpha (dp_one_minus_alpha),
        .dp_obackground     (dp_obackground),
        .out_valid          (out_valid),
        .out_sof            (out_sof),
        .out_eol            (out_eol),
        .out_background     (out_background),
        .busy               (busy)
`ifdef BG_MODEL_CTRL_STATS_EN
        ,
        .frame_cnt          (frame_cnt),
        .init_active        (init_active)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External datapath: separately shifted terms, saturated, 4 register stages, never reset
    function automatic logic [7:0] dp_calc(input logic [7:0] f, input logic [7:0] b,
                                           input logic [7:0] a, input logic [7:0] oma);
        int s;
        s = ((int'(f) * int'(a)) >>> 7) + ((int'(b) * int'(oma)) >>> 7);
        if (s > 255) s = 255;
        return s[7:0];
    endfunction

    logic [7:0] dp_pipe [4];
    always @(posedge clk) begin
        dp_pipe[0] <= dp_calc(dp_frame, dp_background, dp_alpha, dp_one_minus_alpha);
        dp_pipe[1] <= dp_pipe[0];
        dp_pipe[2] <= dp_pipe[1];
        dp_pipe[3] <= dp_pipe[2];
    end
    assign dp_obackground = dp_pipe[3];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every valid beat must match the oldest expected entry, cycle included
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("out_sof", int'(out_sof), int'(e.sof));
                chk("out_eol", int'(out_eol), int'(e.eol));
                chk("out_background", int'(out_background), int'(e.bg));
            end
        end else if (rst_n) begin
            chk("out_background_idle", int'(out_background), 0);
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        cfg_valid = 1'b0; init_req = 1'b0;
    endtask

    // One accepted pixel with optional cfg/init request, expected weight and result
    task automatic pixel(input logic [7:0] f, input logic [7:0] b, input bit sof, input bit eol,
                         input bit cv, input logic [7:0] ca, input bit ir,
                         input int ea, input int eo);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_sof = sof; in_eol = eol;
        in_frame = f; in_background = b;
        cfg_valid = cv; cfg_alpha = ca; init_req = ir;
        #1;
        chk("dp_alpha", int'(dp_alpha), ea);
        chk("dp_one_minus_alpha", int'(dp_one_minus_alpha), 128 - ea);
        chk("dp_frame", int'(dp_frame), int'(f));
        chk("dp_background", int'(dp_background), int'(b));
        e.cyc = cyc + 4; e.sof = sof; e.eol = eol; e.bg = eo[7:0];
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        in_frame = 8'd0; in_background = 8'd0;
        cfg_valid = 1'b0; cfg_alpha = 8'd0; init_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sof", int'(out_sof), 0);
        chk("rst_out_eol", int'(out_eol), 0);
        chk("rst_out_background", int'(out_background), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        idle();
        chk("cfg_ready_after_rst", int'(cfg_ready), 1);

        // Frame 1: forced init frame, output equals input pixels
        pixel(8'd200, 8'd10, 1, 0, 0, 8'd0, 0, 128, 200);
        pixel(8'd50,  8'd90, 0, 0, 0, 8'd0, 0, 128, 50);
`ifdef BG_MODEL_CTRL_STATS_EN
        chk("init_active_f1", int'(init_active), 1);
        chk("frame_cnt_f1", int'(frame_cnt), 1);
`endif
        pixel(8'd7,   8'd3,  0, 1, 0, 8'd0, 0, 128, 7);
        chk("busy_in_frame", int'(busy), 1);

        // Frame 2: reset alpha 8; cfg 200 accepted mid-frame but not applied yet
        pixel(8'd200, 8'd100, 1, 0, 0, 8'd0,   0, 8, 105);
        pixel(8'd100, 8'd200, 0, 0, 0, 8'd0,   0, 8, 193);
        chk("cfg_ready_before_req", int'(cfg_ready), 1);
        pixel(8'd10,  8'd20,  0, 0, 1, 8'd200, 0, 8, 18);
        pixel(8'd20,  8'd40,  0, 0, 0, 8'd0,   0, 8, 38);
        chk("cfg_ready_pending", int'(cfg_ready), 0);
        idle();
        pixel(8'd255, 8'd255, 0, 1, 0, 8'd0,   0, 8, 254);

        // Frame 3: clamped alpha 128 applied at sof
        pixel(8'd100, 8'd50, 1, 0, 0, 8'd0, 0, 128, 100);
        chk("cfg_ready_at_apply_sof", int'(cfg_ready), 0);
        pixel(8'd60,  8'd70, 0, 1, 0, 8'd0, 0, 128, 60);
        chk("cfg_ready_returns", int'(cfg_ready), 1);
`ifdef BG_MODEL_CTRL_STATS_EN
        chk("init_active_f3", int'(init_active), 0);
        chk("frame_cnt_f3", int'(frame_cnt), 3);
`endif

        // Frame 4: cfg 64 on the sof cycle must not affect this frame
        pixel(8'd80, 8'd40, 1, 0, 1, 8'd64, 0, 128, 80);
        pixel(8'd10, 8'd30, 0, 1, 0, 8'd0,  0, 128, 10);

        // Frame 5: alpha 64; init_req pulsed mid-frame
        pixel(8'd100, 8'd20,  1, 0, 0, 8'd0, 0, 64, 60);
        pixel(8'd250, 8'd250, 0, 0, 0, 8'd0, 0, 64, 250);
        pixel(8'd0,   8'd200, 0, 0, 0, 8'd0, 1, 64, 100);
        pixel(8'd30,  8'd60,  0, 1, 0, 8'd0, 0, 64, 45);

        // Frame 6: forced init frame
        pixel(8'd33, 8'd99, 1, 0, 0, 8'd0, 0, 128, 33);
        pixel(8'd44, 8'd11, 0, 1, 0, 8'd0, 0, 128, 44);

        // Frame 7: back to alpha 64; init_req on the sof cycle targets frame 8
        pixel(8'd100, 8'd20, 1, 0, 0, 8'd0, 1, 64, 60);
        pixel(8'd200, 8'd0,  0, 1, 0, 8'd0, 0, 64, 100);
        pixel(8'd9,   8'd250, 1, 0, 0, 8'd0, 0, 128, 9);
        pixel(8'd128, 8'd0,   1, 0, 0, 8'd0, 0, 64, 64);

        // Gapped frame with eol at pixel 3
        pixel(8'd10, 8'd10, 1, 0, 0, 8'd0, 0, 64, 10);
        idle();
        pixel(8'd20, 8'd20, 0, 0, 0, 8'd0, 0, 64, 20);
        idle();
        idle();
        pixel(8'd40, 8'd80, 0, 1, 0, 8'd0, 0, 64, 60);
        pixel(8'd2,  8'd4,  0, 0, 0, 8'd0, 0, 64, 3);
        pixel(8'd6,  8'd8,  0, 0, 0, 8'd0, 0, 64, 7);
        pixel(8'd12, 8'd16, 0, 0, 0, 8'd0, 0, 64, 14);

        // Reset pulse mid-frame: in-flight pixels are dropped
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b0; in_frame = 8'd5; in_background = 8'd5;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        chk("busy_after_rst", int'(busy), 0);
        chk("cfg_ready_in_rst", int'(cfg_ready), 0);
        for (int i = 0; i < 4; i++) begin
            chk("out_valid_after_rst", int'(out_valid), 0);
            @(posedge clk); #1;
        end

        // After reset the next frame is an init frame again
        pixel(8'd77, 8'd1, 1, 0, 0, 8'd0, 0, 128, 77);
        pixel(8'd5,  8'd5, 0, 1, 0, 8'd0, 0, 128, 5);
`ifdef BG_MODEL_CTRL_STATS_EN
        chk("frame_cnt_after_rst", int'(frame_cnt), 1);
        chk("init_active_after_rst", int'(init_active), 1);
`endif
        idle();
        repeat (8) idle();
        chk("busy_state_init", int'(busy), 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
